// File: rtl/fir3_sum_decoder.sv
// Inverse of the 3-tap moving-sum encoder: recovers x[n] = y[n] - x[n-1] - x[n-2].
// Define DEC_ERR_CNT_EN to build the saturating error-event counter on err_count.
module fir3_sum_decoder #(
    parameter int DATA_W     = 4,
    parameter int SUM_W      = 8,
    parameter int RESYNC_LEN = 3
) (
    input  logic              clock_pulse,
    input  logic              clr_de,
    input  logic [SUM_W-1:0]  sum_in,
    input  logic              sum_valid,
    input  logic              resync,
    output logic [DATA_W-1:0] led_out,
    output logic              led_valid,
    output logic              sync_err,
    output logic [7:0]        err_count
);

    localparam int ZC_W = $clog2(RESYNC_LEN + 1);
    localparam logic [ZC_W-1:0] ZC_LAST = ZC_W'(RESYNC_LEN - 1);

    typedef enum logic {RUN = 1'b0, ERROR = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [ZC_W-1:0]         zcnt, zcnt_nxt;
    logic [DATA_W-1:0]       h1_p1, h2_p1, led_p1;
    logic                    vld_p1;
    logic signed [SUM_W+1:0] r_p0;
    logic                    in_range_p0;
    logic                    h_clr, h_load, out_load;

    // Stage p0: combinational decode against the stored history
    always_comb begin
        r_p0 = $signed({2'b00, sum_in})
             - $signed({{(SUM_W + 2 - DATA_W){1'b0}}, h1_p1})
             - $signed({{(SUM_W + 2 - DATA_W){1'b0}}, h2_p1});
        in_range_p0 = ~r_p0[SUM_W+1] && (r_p0[SUM_W:DATA_W] == '0);
    end

    always_ff @(posedge clock_pulse or posedge clr_de) begin
        if (clr_de) begin
            state <= RUN;
            zcnt  <= '0;
        end else begin
            state <= state_nxt;
            zcnt  <= zcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        zcnt_nxt  = zcnt;
        h_clr     = 1'b0;
        h_load    = 1'b0;
        out_load  = 1'b0;
        if (resync) begin
            state_nxt = RUN;
            zcnt_nxt  = '0;
            h_clr     = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (sum_valid) begin
                        if (in_range_p0) begin
                            h_load   = 1'b1;
                            out_load = 1'b1;
                        end else begin
                            state_nxt = ERROR;
                        end
                    end
                end
                ERROR: begin
                    // A run of zero sums implies the encoder's delay line is all zero
                    if (sum_valid) begin
                        if (sum_in == '0) begin
                            if (zcnt == ZC_LAST) begin
                                state_nxt = RUN;
                                zcnt_nxt  = '0;
                                h_clr     = 1'b1;
                            end else begin
                                zcnt_nxt = zcnt + 1'b1;
                            end
                        end else begin
                            zcnt_nxt = '0;
                        end
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Stage p1: history and output registers
    always_ff @(posedge clock_pulse or posedge clr_de) begin
        if (clr_de) begin
            h1_p1  <= '0;
            h2_p1  <= '0;
            led_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= out_load;
            if (h_clr) begin
                h1_p1 <= '0;
                h2_p1 <= '0;
            end else if (h_load) begin
                h2_p1 <= h1_p1;
                h1_p1 <= r_p0[DATA_W-1:0];
            end
            if (out_load) led_p1 <= r_p0[DATA_W-1:0];
        end
    end

    assign led_out   = led_p1;
    assign led_valid = vld_p1;
    assign sync_err  = (state == ERROR);

`ifdef DEC_ERR_CNT_EN
    logic [7:0] err_cnt_p1;
    logic       err_evt_p0;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign err_evt_p0 = (state == RUN) && sum_valid && !resync && !in_range_p0;

    always_ff @(posedge clock_pulse or posedge clr_de) begin
        if (clr_de)          err_cnt_p1 <= '0;
        else if (err_evt_p0) err_cnt_p1 <= sat_inc(err_cnt_p1);
    end

    assign err_count = err_cnt_p1;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fir3_sum_decoder.sv
// Vector-table bench for fir3_sum_decoder with an expected-sample scoreboard.
module tb_fir3_sum_decoder;

    logic       clock_pulse = 1'b0;
    logic       clr_de      = 1'b1;
    logic [7:0] sum_in      = '0;
    logic       sum_valid   = 1'b0;
    logic       resync      = 1'b0;
    logic [3:0] led_out;
    logic       led_valid;
    logic       sync_err;
    logic [7:0] err_count;

`ifdef DEC_ERR_CNT_EN
    localparam bit EC_EN = 1'b1;
`else
    localparam bit EC_EN = 1'b0;
`endif

    fir3_sum_decoder dut (
        .clock_pulse(clock_pulse),
        .clr_de     (clr_de),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .resync     (resync),
        .led_out    (led_out),
        .led_valid  (led_valid),
        .sync_err   (sync_err),
        .err_count  (err_count)
    );

    always #5 clock_pulse = ~clock_pulse;

    typedef struct {
        bit v;
        int s;
        bit rs;
        bit ev;
        int el;
        bit ee;
        int ec;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   sb[$];
    vec_t vecs[24];
    vec_t tail[3];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input string nm);
        int exp_led;
        @(negedge clock_pulse);
        sum_valid = t.v;
        sum_in    = 8'(t.s);
        resync    = t.rs;
        if (t.ev) sb.push_back(t.el);
        @(posedge clock_pulse);
        #1;
        sum_valid = 1'b0;
        resync    = 1'b0;
        chk({nm, "_valid"}, int'(led_valid), (sb.size() > 0) ? 1 : 0);
        if (sb.size() > 0) begin
            exp_led = sb.pop_front();
            if (led_valid) chk({nm, "_sample"}, int'(led_out), exp_led);
        end
        chk({nm, "_led"}, int'(led_out), t.el);
        chk({nm, "_syncerr"}, int'(sync_err), int'(t.ee));
        chk({nm, "_errcnt"}, int'(err_count), EC_EN ? t.ec : 0);
    endtask

    initial begin
        vecs[0]  = '{1, 3,   0, 1, 3, 0, 0};
        vecs[1]  = '{1, 8,   0, 1, 5, 0, 0};
        vecs[2]  = '{1, 15,  0, 1, 7, 0, 0};
        vecs[3]  = '{1, 14,  0, 1, 2, 0, 0};
        vecs[4]  = '{1, 40,  0, 0, 2, 1, 1};
        vecs[5]  = '{1, 0,   0, 0, 2, 1, 1};
        vecs[6]  = '{1, 0,   0, 0, 2, 1, 1};
        vecs[7]  = '{1, 5,   0, 0, 2, 1, 1};
        vecs[8]  = '{1, 0,   0, 0, 2, 1, 1};
        vecs[9]  = '{1, 0,   0, 0, 2, 1, 1};
        vecs[10] = '{1, 0,   0, 0, 2, 0, 1};
        vecs[11] = '{1, 4,   0, 1, 4, 0, 1};
        vecs[12] = '{0, 0,   1, 0, 4, 0, 1};
        vecs[13] = '{1, 3,   0, 1, 3, 0, 1};
        vecs[14] = '{0, 0,   0, 0, 3, 0, 1};
        vecs[15] = '{0, 0,   0, 0, 3, 0, 1};
        vecs[16] = '{1, 8,   0, 1, 5, 0, 1};
        vecs[17] = '{0, 0,   0, 0, 5, 0, 1};
        vecs[18] = '{1, 15,  0, 1, 7, 0, 1};
        vecs[19] = '{1, 14,  0, 1, 2, 0, 1};
        vecs[20] = '{1, 0,   0, 0, 2, 1, 2};
        vecs[21] = '{1, 9,   1, 0, 2, 0, 2};
        vecs[22] = '{1, 9,   0, 1, 9, 0, 2};
        vecs[23] = '{1, 200, 0, 0, 9, 1, 3};
        tail[0]  = '{1, 6,   0, 1, 6,  0, 0};
        tail[1]  = '{1, 21,  0, 1, 15, 0, 0};
        tail[2]  = '{1, 37,  0, 0, 15, 1, 1};

        repeat (3) @(posedge clock_pulse);
        #1;
        chk("rst_led", int'(led_out), 0);
        chk("rst_valid", int'(led_valid), 0);
        chk("rst_syncerr", int'(sync_err), 0);
        chk("rst_errcnt", int'(err_count), 0);
        @(negedge clock_pulse);
        clr_de = 1'b0;

        for (int i = 0; i < 24; i++) step(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset while in ERROR must clear outputs before any clock edge
        @(negedge clock_pulse);
        clr_de = 1'b1;
        #1;
        chk("async_led", int'(led_out), 0);
        chk("async_valid", int'(led_valid), 0);
        chk("async_syncerr", int'(sync_err), 0);
        chk("async_errcnt", int'(err_count), 0);
        @(posedge clock_pulse);
        @(negedge clock_pulse);
        clr_de = 1'b0;

        for (int i = 0; i < 3; i++) step(tail[i], $sformatf("t%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir3_sum_decoder.md
Name: fir3_sum_decoder

Overview:
Receive-side inverse of the 3-tap unity-weight moving-sum filter that drives the 8-bit outhai bus. The encoder computes y[n] = x[n] + x[n-1] + x[n-2] from 4-bit samples. This block recursively recovers x[n] = y[n] - x[n-1] - x[n-2] from the sum stream. It also detects out-of-range results, which indicate loss of sync, and re-synchronises on a run of zero sums.

Parameters:
DATA_W, 4, width of recovered sample; legal range 0..2^DATA_W-1
SUM_W, 8, width of incoming sum word
RESYNC_LEN, 3, consecutive zero sums required to leave ERROR (must be >= 2, i.e. taps-1, for guaranteed zero history)

Ports:
clock_pulse  in  1  clock, rising edge
clr_de  in  1  reset, asynchronous, active-high
sum_in  in  SUM_W  moving-sum word from the encoder
sum_valid  in  1  sum_in valid this cycle; no backpressure
resync  in  1  soft resync: clear history, force RUN
led_out  out  DATA_W  recovered sample
led_valid  out  1  one-cycle pulse, led_out valid
sync_err  out  1  high while in ERROR
err_count  out  8  error-event count (optional feature; 0 otherwise)

Behaviour:
- Reset (clr_de=1, async): state=RUN; history h1=h2=0; zero counter=0; led_out=0; led_valid=0; sync_err=0; err_count=0. Zero history matches the encoder's cleared delay line.
- States: RUN and ERROR. There is no idle state; the block accepts samples the cycle after reset deasserts.
- Arithmetic: r = sum_in - h1 - h2, computed signed in SUM_W+2 bits, zero-extending all operands. r is in range iff 0 <= r <= 2^DATA_W-1.
- RUN, sum_valid=1, r in range:
  - next cycle led_out=r[DATA_W-1:0] and led_valid=1 (latency 1 clock);
  - h2<=h1, h1<=r.
- RUN, sum_valid=1, r out of range:
  - next state ERROR; sync_err=1 next cycle;
  - led_valid stays 0; led_out holds its last value; history is frozen;
  - error event counted.
- RUN, sum_valid=0: no change; led_valid=0.
- ERROR:
  - every valid sum_in==0 increments the zero counter;
  - a valid nonzero sum_in clears the zero counter;
  - no led_valid output in ERROR.
  - When a valid zero brings the counter to RESYNC_LEN: next state RUN, h1=h2=0, counter=0, sync_err=0. The triggering zero sample is not output.
  - The first valid sum after re-entering RUN is decoded against zero history.
- resync=1 (any state): next cycle state=RUN, h1=h2=0, zero counter=0, sync_err=0, led_valid=0. The sample is dropped if sum_valid is also high in that cycle; resync has priority.
- sum_in above 3*(2^DATA_W-1)=45 always decodes out of range. No special case is needed.
- Reset mid-operation aborts immediately; there is no partial-output pulse.
- led_valid is never high in two consecutive cycles unless sum_valid was high in two consecutive cycles.

Optional Feature:
DEC_ERR_CNT_EN
- Defined: err_count increments once per RUN->ERROR transition and saturates at 255. It is cleared only by clr_de; resync does not clear it.
- Undefined: err_count is tied to 0. No counter logic is built. The port remains present.

Test Plan:
- Reset, then valid sums 3, 8, 15, 14 (encoder input 3,5,7,2) -> led_out 3, 5, 7, 2. Each value appears with a single led_valid pulse one cycle after its sum_valid; sync_err=0.
- sum_valid gapped (3, idle 2 cycles, 8, idle, 15) -> outputs 3, 5, 7. History is unaffected by the idle cycles; led_valid=0 in idle cycles.
- History (h1=2, h2=7), then sum 40 (r=31) -> no led_valid; sync_err=1 next cycle; led_out holds 2; err_count=1 with DEC_ERR_CNT_EN, 0 without.
- In ERROR, sums 0, 0, 5, 0, 0, 0 -> ERROR persists through the 5 (counter cleared); RUN after the third consecutive zero; then sum 4 -> led_out=4, led_valid=1.
- From RUN with history (7,2): sum 0 (r=-9) -> ERROR. Then resync=1 together with sum_valid=1 and sum_in=9 -> sample dropped, state RUN, history zero. Next sum 9 -> led_out=9.
- clr_de pulsed while in ERROR with err_count=3 -> all outputs 0 asynchronously; state RUN; first sum 6 -> led_out=6.
